// File: rtl/fpadd_seq_ctrl.sv
// Sequencing and display controller for the FP adder demo: issues one operand pair per
// request, captures the sum after the adder latency and scans the result onto hex digits.
module fpadd_seq_ctrl #(
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int LATENCY  = 4,
   parameter int SCAN_DIV = 50000,
   parameter int DIGITS   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              button,
   input  logic              auto_mode,
   input  logic              half_sel,
   output logic [ADDR_W-1:0] addr,
   output logic              issue_valid,
   input  logic [31:0]       fp_out,
   output logic [31:0]       result_q,
   output logic              result_valid,
   output logic              overrun,
   output logic [DIGITS-1:0] anode,
   output logic [3:0]        nibble
);

   localparam int                DIV_W      = $clog2(SCAN_DIV);
   localparam logic [3:0]        WAIT_LOAD  = 4'(LATENCY - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]        DIGIT_LAST = 3'(DIGITS - 1);
   localparam logic [DIGITS-1:0] DIGIT0_HOT = DIGITS'(1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              w_start;
   logic              w_capture;
   logic [3:0]        r_waitCnt;
   logic              r_pending;
   logic              r_overrun;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_result;
   logic              r_resultValid;

   logic [DIV_W-1:0]  r_div;
   logic [2:0]        r_digit;
   logic [2:0]        w_nextDigit;
   logic [15:0]       w_half;
   logic [31:0]       w_dispWord;
   logic [4:0]        w_nibIdx;
   logic [3:0]        w_nibNext;
   logic [DIGITS-1:0] r_anode;
   logic [3:0]        r_nibble;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // WAIT always spans LATENCY cycles, so fp_out is sampled exactly LATENCY cycles
   // after the ISSUE cycle and the capture lands on the edge entering CAPTURE.
   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (button || r_pending || auto_mode) begin
               w_start     = 1'b1;
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            w_nextState = WAIT;
         end
         WAIT: begin
            if (r_waitCnt == 4'd0) begin
               w_capture   = 1'b1;
               w_nextState = CAPTURE;
            end
         end
         CAPTURE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waitCnt <= 4'd0;
      end else if (r_state == ISSUE) begin
         r_waitCnt <= WAIT_LOAD;
      end else if (r_state == WAIT && r_waitCnt != 4'd0) begin
         r_waitCnt <= r_waitCnt - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result      <= 32'd0;
         r_addr        <= '0;
         r_resultValid <= 1'b0;
      end else begin
         r_resultValid <= w_capture;
         if (w_capture) begin
            r_result <= fp_out;
            r_addr   <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
         end
      end
   end

   // A press arriving while IDLE consumes a pending request stays queued behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else if (r_state == IDLE) begin
         if (w_start) begin
            r_pending <= r_pending & button;
         end
      end else if (button) begin
         if (r_pending) begin
            r_overrun <= 1'b1;
         end else begin
            r_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nextDigit = (r_digit == DIGIT_LAST) ? 3'd0 : r_digit + 3'd1;
      w_half      = half_sel ? r_result[31:16] : r_result[15:0];
      w_dispWord  = (DIGITS == 4) ? {16'd0, w_half} : r_result;
      w_nibIdx    = {w_nextDigit, 2'b00};
      w_nibNext   = w_dispWord[w_nibIdx +: 4];
   end

   // Digit enable and value are loaded together on each divider wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div    <= '0;
         r_digit  <= 3'd0;
         r_anode  <= ~DIGIT0_HOT;
         r_nibble <= 4'd0;
      end else if (r_div == DIV_LAST) begin
         r_div    <= '0;
         r_digit  <= w_nextDigit;
         r_anode  <= ~(DIGIT0_HOT << w_nextDigit);
         r_nibble <= w_nibNext;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign addr         = r_addr;
   assign issue_valid  = (r_state == ISSUE);
   assign result_q     = r_result;
   assign result_valid = r_resultValid;
   assign overrun      = r_overrun;
   assign anode        = r_anode;
   assign nibble       = r_nibble;

endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// Scoreboard bench for fpadd_seq_ctrl: a timing-level request model predicts issues,
// captures, overrun and the display scan for an 8-digit and a 4-digit instance.
module tb_fpadd_seq_ctrl;

   localparam int DEPTH    = 5;
   localparam int ADDR_W   = 3;
   localparam int LATENCY  = 4;
   localparam int SCAN_DIV = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              button;
   logic              autoMode;
   logic              halfSel;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr4;
   logic              issueValid;
   logic              issueValid4;
   logic [31:0]       fpOut;
   logic [31:0]       resultQ;
   logic [31:0]       resultQ4;
   logic              resultValid;
   logic              resultValid4;
   logic              overrun;
   logic              overrun4;
   logic [7:0]        anode;
   logic [3:0]        anode4;
   logic [3:0]        nibble;
   logic [3:0]        nibble4;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   fpadd_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY),
                    .SCAN_DIV(SCAN_DIV), .DIGITS(8)) dut (
      .clk(clk), .rst(rst), .button(button), .auto_mode(autoMode), .half_sel(halfSel),
      .addr(addr), .issue_valid(issueValid), .fp_out(fpOut), .result_q(resultQ),
      .result_valid(resultValid), .overrun(overrun), .anode(anode), .nibble(nibble)
   );

   fpadd_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY),
                    .SCAN_DIV(SCAN_DIV), .DIGITS(4)) dut4 (
      .clk(clk), .rst(rst), .button(button), .auto_mode(autoMode), .half_sel(halfSel),
      .addr(addr4), .issue_valid(issueValid4), .fp_out(fpOut), .result_q(resultQ4),
      .result_valid(resultValid4), .overrun(overrun4), .anode(anode4), .nibble(nibble4)
   );

   // Operand memory holds small integers encoded as floats, so sums are exact.
   int          opA [2**ADDR_W];
   int          opB [2**ADDR_W];
   logic [31:0] sums [2**ADDR_W];
   logic [31:0] pipe [LATENCY];

   function automatic logic [31:0] intToFloat(input int n);
      int          msb;
      logic [31:0] m;
      msb = 0;
      for (int i = 0; i < 31; i++) if (n[i]) msb = i;
      m = 32'(n) << (23 - msb);
      return {1'b0, 8'(127 + msb), m[22:0]};
   endfunction

   // Adder stand-in: LATENCY-stage pipeline, fed junk whenever nothing is issued.
   always @(posedge clk) begin
      pipe[0] <= issueValid ? sums[addr] : $urandom();
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign fpOut = pipe[LATENCY-1];

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] a;
   } issueExp_t;

   typedef struct {
      int                cyc;
      logic [31:0]       v;
      logic [ADDR_W-1:0] a;
   } resExp_t;

   issueExp_t expIssues[$];
   resExp_t   expResults[$];
   resExp_t   resultSched[$];

   int          idleAt;
   int          dispBase;
   int          modelAddr;
   bit          modelPending;
   bit          modelOverrun;
   logic [31:0] modelResult;
   logic [3:0]  dispNib8;
   logic [3:0]  dispNib4;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, actual, expected, cycle);
      end
   endtask

   task automatic resetModel();
      dispBase     = cycle;
      idleAt       = cycle;
      modelAddr    = 0;
      modelPending = 0;
      modelOverrun = 0;
      modelResult  = 32'd0;
      dispNib8     = 4'd0;
      dispNib4     = 4'd0;
      expIssues.delete();
      expResults.delete();
      resultSched.delete();
   endtask

   task automatic checkResetValues();
      checkOutput("rst_result_q", resultQ, 32'd0);
      checkOutput("rst_addr", 32'(addr), 32'd0);
      checkOutput("rst_issue_valid", 32'(issueValid), 32'd0);
      checkOutput("rst_result_valid", 32'(resultValid), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      checkOutput("rst_anode", 32'(anode), 32'hFE);
      checkOutput("rst_nibble", 32'(nibble), 32'd0);
      checkOutput("rst_anode4", 32'(anode4), 32'hE);
   endtask

   // One cycle of the request model: a request starting in an idle cycle c issues
   // at c+1, shows its result at c+LATENCY+2 and frees the block at c+LATENCY+3.
   task automatic modelStep(input bit b, input bit a);
      int          c;
      int          k;
      int          d8;
      int          d4;
      int          na;
      logic [7:0]  ex8;
      logic [3:0]  ex4;
      logic [15:0] half;
      c = cycle;
      if (resultSched.size() > 0 && resultSched[0].cyc == c) begin
         modelResult = resultSched[0].v;
         void'(resultSched.pop_front());
      end
      k   = c - dispBase;
      d8  = (k / SCAN_DIV) % 8;
      d4  = (k / SCAN_DIV) % 4;
      ex8 = ~(8'd1 << d8);
      ex4 = ~(4'd1 << d4);
      checkOutput("anode8", 32'(anode), 32'(ex8));
      checkOutput("nibble8", 32'(nibble), 32'(dispNib8));
      checkOutput("anode4", 32'(anode4), 32'(ex4));
      checkOutput("nibble4", 32'(nibble4), 32'(dispNib4));
      checkOutput("overrun", 32'(overrun), 32'(modelOverrun));
      checkOutput("overrun4", 32'(overrun4), 32'(modelOverrun));
      if (k % SCAN_DIV == SCAN_DIV - 1) begin
         d8       = (k / SCAN_DIV + 1) % 8;
         d4       = (k / SCAN_DIV + 1) % 4;
         dispNib8 = modelResult[4*d8 +: 4];
         half     = halfSel ? modelResult[31:16] : modelResult[15:0];
         dispNib4 = half[4*d4 +: 4];
      end
      if (c >= idleAt) begin
         if (b || modelPending || a) begin
            na = (modelAddr + 1) % DEPTH;
            expIssues.push_back(issueExp_t'{c + 1, ADDR_W'(modelAddr)});
            expResults.push_back(resExp_t'{c + LATENCY + 2, sums[modelAddr], ADDR_W'(na)});
            resultSched.push_back(resExp_t'{c + LATENCY + 2, sums[modelAddr], ADDR_W'(na)});
            modelAddr    = na;
            idleAt       = c + LATENCY + 3;
            modelPending = modelPending && b;
         end
      end else if (b) begin
         if (modelPending) modelOverrun = 1;
         else modelPending = 1;
      end
   endtask

   task automatic applyStimulus(input bit b, input bit a);
      button   = b;
      autoMode = a;
      if ($urandom_range(0, 49) == 0) halfSel = ~halfSel;
      modelStep(b, a);
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an issue or a result.
   always @(negedge clk) begin
      if (!rst) begin
         while (expIssues.size() > 0 && expIssues[0].cyc < cycle) begin
            checkOutput("issue_missing", 32'd0, 32'd1);
            void'(expIssues.pop_front());
         end
         while (expResults.size() > 0 && expResults[0].cyc < cycle) begin
            checkOutput("result_missing", 32'd0, 32'd1);
            void'(expResults.pop_front());
         end
         if (issueValid) begin
            if (expIssues.size() == 0) begin
               checkOutput("unexpected_issue", 32'd1, 32'd0);
            end else begin
               checkOutput("issue_cycle", 32'(cycle), 32'(expIssues[0].cyc));
               checkOutput("issue_addr", 32'(addr), 32'(expIssues[0].a));
               checkOutput("issue_valid4", 32'(issueValid4), 32'd1);
               checkOutput("issue_addr4", 32'(addr4), 32'(expIssues[0].a));
               void'(expIssues.pop_front());
            end
         end
         if (resultValid) begin
            if (expResults.size() == 0) begin
               checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
               checkOutput("result_cycle", 32'(cycle), 32'(expResults[0].cyc));
               checkOutput("result_q", resultQ, expResults[0].v);
               checkOutput("result_addr", 32'(addr), 32'(expResults[0].a));
               checkOutput("result_valid4", 32'(resultValid4), 32'd1);
               checkOutput("result_q4", resultQ4, expResults[0].v);
               void'(expResults.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
         opA[i]  = $urandom_range(1, 1000);
         opB[i]  = $urandom_range(1, 1000);
      end
      opA[0] = 1;
      opB[0] = 2;
      for (int i = 0; i < 2**ADDR_W; i++) sums[i] = intToFloat(opA[i] + opB[i]);

      rst      = 1'b1;
      button   = 1'b0;
      autoMode = 1'b0;
      halfSel  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      checkResetValues();

      // Single press: pair 0 is 1.0 + 2.0
      repeat (10) applyStimulus(0, 0);
      applyStimulus(1, 0);
      repeat (15) applyStimulus(0, 0);

      // Queued press then overrun
      applyStimulus(1, 0);
      applyStimulus(0, 0);
      applyStimulus(1, 0);
      applyStimulus(1, 0);
      repeat (20) applyStimulus(0, 0);

      repeat (300) applyStimulus($urandom_range(0, 7) == 0, 0);
      repeat (15) applyStimulus(0, 0);

      // Auto mode, dropped part-way through an operation
      repeat (40) applyStimulus(0, 1);
      repeat (20) applyStimulus(0, 0);

      // Reset in the middle of WAIT
      applyStimulus(1, 0);
      repeat (3) applyStimulus(0, 0);
      rst = 1'b1;
      #1;
      checkResetValues();
      expIssues.delete();
      expResults.delete();
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      repeat (20) applyStimulus(0, 0);
      checkOutput("addr_after_reset", 32'(addr), 32'd0);

      repeat (300) applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      repeat (30) applyStimulus(0, 0);

      checkOutput("issues_drained", 32'(expIssues.size()), 32'd0);
      checkOutput("results_drained", 32'(expResults.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
